// File: rtl/sensor_event_encoder_pkg.sv
// Shared definitions for the sensor event encoder and its decoder-side peers.
package sensor_event_encoder_pkg;

    localparam int N_SENSORS = 16;
    localparam int CODE_W    = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Binary code to one-hot line mask; the same mapping the 4-to-16 decoder uses.
    function automatic logic [N_SENSORS-1:0] onehot16(input logic [CODE_W-1:0] code);
        logic [N_SENSORS-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sensor_event_encoder_priority.sv
// Combinational 16-to-4 priority encoder, lowest set index wins.
module priority_encoder_16x4
    import sensor_event_encoder_pkg::*;
(
    input  logic [N_SENSORS-1:0] req,
    output logic                 any,
    output logic [CODE_W-1:0]    idx
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/sensor_event_encoder.sv
// Turns rising edges on 16 sensor lines into a stream of 4-bit event codes
// on a valid/ready interface, with round-robin or fixed-priority arbitration.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | nothing presented; load a code as soon as pending != 0
// PRESENT | evt_code valid and held until accepted; reload on accept
module sensor_event_encoder
    import sensor_event_encoder_pkg::*;
#(
    parameter int RR_EN      = 1,
    parameter int DROP_CNT_W = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SENSORS-1:0]  sensor_in,
    input  logic                  evt_ready,
    output logic                  evt_valid,
    output logic [CODE_W-1:0]     evt_code,
    output logic [N_SENSORS-1:0]  pending,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t                state_q;
    state_t                state_d;
    logic [N_SENSORS-1:0]  sensor_q;
    logic [N_SENSORS-1:0]  rise;
    logic [N_SENSORS-1:0]  clr;
    logic [N_SENSORS-1:0]  sel_req;
    logic [N_SENSORS-1:0]  rot_req;
    logic [CODE_W-1:0]     last;
    logic [CODE_W-1:0]     last_d;
    logic [CODE_W-1:0]     shift;
    logic [CODE_W-1:0]     enc_idx;
    logic [CODE_W-1:0]     grant;
    logic [CODE_W-1:0]     code_d;
    logic                  enc_any;
    logic                  accept;
    logic                  drop_hit;

    assign evt_valid = (state_q == PRESENT);
    assign accept    = evt_valid & evt_ready;
    assign rise      = sensor_in & ~sensor_q;
    assign clr       = accept ? onehot16(evt_code) : '0;
    // Selection works on registered pending minus the bit being accepted now,
    // so rises arriving this cycle are never granted in the same cycle.
    assign sel_req   = pending & ~clr;
    assign drop_hit  = |(rise & sel_req);
    // 4-bit add wraps 15 -> 0, giving the round-robin start point.
    assign shift     = last + CODE_W'(1);

    // Rotate requests right by last+1 so the encoder's lowest index is the next in turn.
    always_comb begin
        rot_req = '0;
        grant   = '0;
        if (RR_EN != 0) begin
            for (int i = 0; i < N_SENSORS; i++) begin
                rot_req[i] = sel_req[CODE_W'(i) + shift];
            end
            grant = enc_idx + shift;
        end else begin
            rot_req = sel_req;
            grant   = enc_idx;
        end
    end

    priority_encoder_16x4 u_penc (
        .req (rot_req),
        .any (enc_any),
        .idx (enc_idx)
    );

    // Next-state and presented-code selection.
    always_comb begin
        state_d = state_q;
        code_d  = evt_code;
        last_d  = last;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d = PRESENT;
                    code_d  = grant;
                    last_d  = grant;
                end
            end
            PRESENT: begin
                if (accept) begin
                    if (enc_any) begin
                        code_d = grant;
                        last_d = grant;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, presented code and arbitration pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            evt_code <= '0;
            last     <= CODE_W'(N_SENSORS - 1);
        end else begin
            state_q  <= state_d;
            evt_code <= code_d;
            last     <= last_d;
        end
    end

    // Edge detect, pending mask (set wins over clear) and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sensor_q <= '0;
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            sensor_q <= sensor_in;
            pending  <= sel_req | rise;
            if (drop_hit && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/sensor_event_encoder.md
Name: sensor_event_encoder

Overview:
- Converts the 16 one-per-decoration trigger/sensor lines into a stream of 4-bit event codes, one code per handshake.
- It is the inverse of the 4-to-16 one-hot decoder that drives the decorations.
- Latches each rising edge as a pending event, arbitrates between pending events, and presents one binary code at a time on a valid/ready interface.
- Sits between the sensor inputs and the sequencing logic that decides which decoration to animate.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration among pending events; 0 = fixed priority, lowest index wins.
- DROP_CNT_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- sensor_in  input  16  level sensor lines, synchronous to clk; bit i = decoration i.
- evt_ready  input  1  consumer accepts evt_code when high with evt_valid.
- evt_valid  output  1  evt_code holds a valid event.
- evt_code  output  4  binary index of the presented event.
- pending  output  16  registered mask of latched, not yet accepted events.
- drop_cnt  output  DROP_CNT_W  count of events lost because the bit was already pending.

Behaviour:
- Reset (rst_n low at a clk edge): evt_valid=0, evt_code=0, pending=0, drop_cnt=0, sensor_q=0, arbitration pointer last=15, state IDLE.
  - sensor_q resets to 0, so a line held high through reset produces one event after release.
  - Reset mid-operation discards all pending and presented events with no partial handshake.
- Edge detect: rise = sensor_in & ~sensor_q, evaluated each cycle; sensor_q <= sensor_in.
- Pending update: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of evt_code when evt_valid && evt_ready, else 0.
  - If a bit rises in the same cycle it is cleared, set wins and the new event stays pending.
- Drop: a rise on a bit already pending and not cleared that cycle increments drop_cnt.
  - drop_cnt saturates at all-ones.
  - Multiple simultaneous drops in one cycle count as 1.
- State machine (2 states):
  - IDLE: evt_valid=0. If pending != 0, select an index, load evt_code, set evt_valid=1 and go to PRESENT.
  - PRESENT: evt_valid=1; evt_code and evt_valid are held stable while evt_ready=0.
    - On accept, if (pending & ~clr) != 0, load the next selection and stay in PRESENT, giving 1 event/cycle throughput.
    - On accept with nothing else pending, go to IDLE with evt_valid=0.
  - In both states, the selection ignores rises arriving in the current cycle because it uses registered pending.
- Latency: input rises before edge k; pending bit set at edge k; evt_valid/evt_code updated at edge k+1 (2 edges) when idle.
- Arbitration:
  - RR_EN=1: search starts at (last+1) mod 16, wrapping 15->0; last <= granted index on each load.
  - RR_EN=0: lowest set index wins; last is unused.
- The presented bit stays set in pending until accepted.
- Outputs are registered; there is no combinational path from evt_ready to evt_valid or evt_code.

Decomposition:
- Shared package holds:
  - N_SENSORS=16 and CODE_W=4;
  - the state enum {IDLE, PRESENT};
  - a function onehot16(code) used for clr (and shared with the decoder side).
- One natural sub-module, priority_encoder_16x4 (combinational): req[15:0] -> any, idx[3:0], lowest index first.
- Round-robin is built around it by rotating req right by last+1, then adding the offset back mod 16.

Test Plan:
- Reset: rst_n=0 for 2 cycles with sensor_in=0x0000 -> evt_valid=0, evt_code=0, pending=0x0000, drop_cnt=0; rst_n=1 with sensor_in=0x0001 held -> exactly one event with code 0.
- Single event: sensor_in 0x0000->0x0020 before edge k, evt_ready=1 -> pending=0x0020 at k; evt_valid=1, evt_code=5 at k+1 only; pending=0x0000 at k+2.
- Simultaneous: sensor_in 0x0000->0x8101, evt_ready=1, RR_EN=1 -> codes 0, 8, 15 on three consecutive cycles, then evt_valid=0.
- Backpressure/drop:
  - Setup: evt_ready=0, bit 3 pending and presented.
  - Stimulus: pulse bit 3 low then high twice.
  - Required response: evt_code stays 3; drop_cnt=2; after evt_ready=1 for one cycle, code 3 delivered once.
  - Repeat with a rise coinciding with the accept cycle -> bit 3 re-pending, no drop.
- Fairness: bits 2 and 9 re-pulsed every accept, evt_ready=1 -> grants 2, 9, 2, 9 with RR_EN=1; with RR_EN=0 -> grant 2 always precedes 9.
- Saturation/reset mid-op:
  - Force 300 drops -> drop_cnt=255.
  - Assert rst_n=0 while evt_valid=1 -> next edge evt_valid=0, pending=0, drop_cnt=0.
